// File: rtl/poly_root_scanner.sv
// Root-bracket scanner: sweeps x over [x_lo, x_hi], requests a*x^2+b*x+c from the solver per x,
// and stops at the first zero or sign change. Optional watchdog macro: POLY_ROOT_SCANNER_TIMEOUT_EN.
module poly_root_scanner
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] c,
    input  logic signed [7:0]  x_lo,
    input  logic signed [7:0]  x_hi,
    output logic               sol_start,
    output logic signed [7:0]  sol_x,
    output logic signed [15:0] sol_a,
    output logic signed [15:0] sol_b,
    output logic signed [15:0] sol_c,
    input  logic               sol_ready,
    input  logic               sol_valid,
    input  logic signed [15:0] sol_result,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic signed [7:0]  root_x,
    output logic signed [15:0] root_val,
    output logic [8:0]         eval_count,
    output logic               timeout
);

    localparam int unsigned X_W = 8;
    localparam int unsigned C_W = 16;
    localparam int unsigned N_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic signed [C_W-1:0] r_a;
    logic signed [C_W-1:0] r_b;
    logic signed [C_W-1:0] r_c;
    logic signed [C_W-1:0] w_a_nxt;
    logic signed [C_W-1:0] w_b_nxt;
    logic signed [C_W-1:0] w_c_nxt;
    logic signed [X_W-1:0] r_cur_x;
    logic signed [X_W-1:0] w_cur_x_nxt;
    logic signed [X_W-1:0] r_x_hi;
    logic signed [X_W-1:0] w_x_hi_nxt;
    logic signed [C_W-1:0] r_res;
    logic signed [C_W-1:0] w_res_nxt;
    logic                  r_prev_neg;
    logic                  w_prev_neg_nxt;
    logic                  r_first;
    logic                  w_first_nxt;

    logic                  r_sol_start;
    logic                  w_sol_start_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_found;
    logic                  w_found_nxt;
    logic signed [X_W-1:0] r_root_x;
    logic signed [X_W-1:0] w_root_x_nxt;
    logic signed [C_W-1:0] r_root_val;
    logic signed [C_W-1:0] w_root_val_nxt;
    logic [N_W-1:0]        r_eval_count;
    logic [N_W-1:0]        w_eval_count_nxt;

`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [TMO_W-1:0]      w_tmo_cnt_nxt;
`endif

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_cur_x      <= '0;
            r_x_hi       <= '0;
            r_res        <= '0;
            r_prev_neg   <= 1'b0;
            r_first      <= 1'b0;
            r_sol_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_root_x     <= '0;
            r_root_val   <= '0;
            r_eval_count <= '0;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
            r_timeout    <= 1'b0;
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_c          <= w_c_nxt;
            r_cur_x      <= w_cur_x_nxt;
            r_x_hi       <= w_x_hi_nxt;
            r_res        <= w_res_nxt;
            r_prev_neg   <= w_prev_neg_nxt;
            r_first      <= w_first_nxt;
            r_sol_start  <= w_sol_start_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_found      <= w_found_nxt;
            r_root_x     <= w_root_x_nxt;
            r_root_val   <= w_root_val_nxt;
            r_eval_count <= w_eval_count_nxt;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
            r_timeout    <= w_timeout_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
`endif
        end
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_c_nxt          = r_c;
        w_cur_x_nxt      = r_cur_x;
        w_x_hi_nxt       = r_x_hi;
        w_res_nxt        = r_res;
        w_prev_neg_nxt   = r_prev_neg;
        w_first_nxt      = r_first;
        w_sol_start_nxt  = 1'b0;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_found_nxt      = r_found;
        w_root_x_nxt     = r_root_x;
        w_root_val_nxt   = r_root_val;
        w_eval_count_nxt = r_eval_count;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
        w_timeout_nxt    = r_timeout;
        w_tmo_cnt_nxt    = r_tmo_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_a_nxt          = a;
                    w_b_nxt          = b;
                    w_c_nxt          = c;
                    w_x_hi_nxt       = x_hi;
                    w_cur_x_nxt      = x_lo;
                    w_first_nxt      = 1'b1;
                    w_found_nxt      = 1'b0;
                    w_root_x_nxt     = '0;
                    w_root_val_nxt   = '0;
                    w_eval_count_nxt = '0;
                    w_busy_nxt       = 1'b1;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
                    w_timeout_nxt    = 1'b0;
`endif
                    w_state_nxt      = (x_lo > x_hi) ? S_DONE : S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (sol_ready) begin
                    w_sol_start_nxt = 1'b1;
                    w_state_nxt     = S_WAIT;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
                    w_tmo_cnt_nxt   = '0;
`endif
                end
            end

            S_WAIT: begin
                if (sol_valid) begin
                    w_res_nxt        = sol_result;
                    w_eval_count_nxt = r_eval_count + N_W'(1);
                    w_state_nxt      = S_CHECK;
                end
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout_nxt = 1'b1;
                    w_found_nxt   = 1'b0;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
`endif
            end

            // x_hi compare happens before the increment so x_hi = 127 never wraps
            S_CHECK: begin
                if (r_res == '0) begin
                    w_found_nxt    = 1'b1;
                    w_root_x_nxt   = r_cur_x;
                    w_root_val_nxt = '0;
                    w_state_nxt    = S_DONE;
                end else if (!r_first && (r_res[C_W-1] != r_prev_neg)) begin
                    w_found_nxt    = 1'b1;
                    w_root_x_nxt   = r_cur_x;
                    w_root_val_nxt = r_res;
                    w_state_nxt    = S_DONE;
                end else if (r_cur_x == r_x_hi) begin
                    w_found_nxt    = 1'b0;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_prev_neg_nxt = r_res[C_W-1];
                    w_first_nxt    = 1'b0;
                    w_cur_x_nxt    = r_cur_x + X_W'(1);
                    w_state_nxt    = S_ISSUE;
                end
            end

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign sol_start  = r_sol_start;
    assign sol_x      = r_cur_x;
    assign sol_a      = r_a;
    assign sol_b      = r_b;
    assign sol_c      = r_c;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign root_x     = r_root_x;
    assign root_val   = r_root_val;
    assign eval_count = r_eval_count;
`ifdef POLY_ROOT_SCANNER_TIMEOUT_EN
    assign timeout    = r_timeout;
`else
    assign timeout    = 1'b0;
`endif

endmodule
